// File: rtl/usbf_ep_rx_buf_pkg.sv
// Shared configuration for the endpoint RX buffer: field widths, max packet
// size and buffer FSM state encoding.
// Ports: none (package).
package usbf_ep_rx_buf_pkg;

  localparam int USB_MAX_PKT_SIZE       = 64;
  localparam int USB_EP0_STS_RX_COUNT_W = $clog2(USB_MAX_PKT_SIZE) + 1;
  localparam int USB_EP0_DATA_DATA_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_READY = 2'd2
  } rx_state_e;

endpackage

// File: rtl/usbf_sp_ram.sv
// Purpose: DEPTH x DW single-write-port RAM with a registered, clearable read port.
// Latency: read data appears the cycle after re_i; rclr_i zeroes the read register.
// Backpressure: none; one write and one read per cycle, contents are not reset.
// Ports: clk_i/rstn_i clock and sync active-low reset (read register only);
//        we_i/waddr_i/wdata_i write port; re_i/raddr_i read; rclr_i zero read reg;
//        rdata_o registered read data.
module usbf_sp_ram #(
  parameter int DEPTH = 64,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic          rclr_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Clear has priority over a read so a zero can be presented as "no more data".
  always_ff @(posedge clk_i) begin
    if (!rstn_i || rclr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/usbf_ep_rx_buf.sv
// Purpose: per-endpoint RX packet buffer (PHY clock domain) with host status/read side.
// Latency: status one cycle after pkt_end_i; rd_data_o one cycle after rd_req_i.
// Backpressure: rx_busy_o high while a packet is held, engine NAKs OUT; SETUP preempts.
// Ports: pkt_* / wr_* from the protocol engine; rd_req_i, rx_accept_i, rx_flush_i
//        synchronized host pulses; rd_data_o and rx_* status levels toward hclk side.
module usbf_ep_rx_buf
  import usbf_ep_rx_buf_pkg::*;
#(
  parameter int DEPTH = USB_MAX_PKT_SIZE,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             phy_clk_i,
  input  logic             rstn_i,
  input  logic             pkt_start_i,
  input  logic             pkt_setup_i,
  input  logic             wr_valid_i,
  input  logic [7:0]       wr_data_i,
  input  logic             pkt_end_i,
  input  logic             pkt_crc_err_i,
  input  logic             rd_req_i,
  input  logic             rx_accept_i,
  input  logic             rx_flush_i,
  output logic [7:0]       rd_data_o,
  output logic             rx_busy_o,
  output logic             rx_ready_o,
  output logic             rx_setup_o,
  output logic             rx_err_o,
  output logic [CNT_W-1:0] rx_count_o,
  output logic             rx_ready_intr_o
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             setup_lat_q, setup_lat_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             setup_q, setup_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             intr_q, intr_d;

  logic             ram_we, ram_re, ram_clr;
  logic             ovf_hit;

  always_ff @(posedge phy_clk_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      setup_lat_q <= 1'b0;
      ovf_q       <= 1'b0;
      ready_q     <= 1'b0;
      setup_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      setup_lat_q <= setup_lat_d;
      ovf_q       <= ovf_d;
      ready_q     <= ready_d;
      setup_q     <= setup_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      intr_q      <= intr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    setup_lat_d = setup_lat_q;
    ovf_d       = ovf_q;
    ready_d     = ready_q;
    setup_d     = setup_q;
    err_d       = err_q;
    busy_d      = busy_q;
    intr_d      = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_clr     = 1'b0;
    // Overflow seen so far, including a byte arriving this cycle into a full buffer.
    ovf_hit     = ovf_q | (wr_valid_i & (wr_ptr_q == DEPTH_C));

    if (rx_flush_i) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      setup_lat_d = 1'b0;
      ovf_d       = 1'b0;
      ready_d     = 1'b0;
      setup_d     = 1'b0;
      err_d       = 1'b0;
      busy_d      = 1'b0;
      ram_clr     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pkt_start_i) begin
            state_d     = ST_RECV;
            wr_ptr_d    = '0;
            setup_lat_d = pkt_setup_i;
            ovf_d       = 1'b0;
          end
        end

        ST_RECV: begin
          if (pkt_start_i) begin
            // A new token restarts capture; the partial packet is abandoned.
            wr_ptr_d    = '0;
            setup_lat_d = pkt_setup_i;
            ovf_d       = 1'b0;
          end else begin
            if (wr_valid_i) begin
              if (wr_ptr_q < DEPTH_C) begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + ONE_C;
              end else begin
                ovf_d = 1'b1;
              end
            end
            if (pkt_end_i) begin
              if (pkt_crc_err_i || ovf_hit) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
              end else begin
                state_d  = ST_READY;
                ready_d  = 1'b1;
                err_d    = 1'b0;
                count_d  = wr_ptr_d;
                setup_d  = setup_lat_q;
                rd_ptr_d = '0;
                busy_d   = 1'b1;
                intr_d   = 1'b1;
              end
            end
          end
        end

        ST_READY: begin
          if (rx_accept_i) begin
            state_d = ST_IDLE;
            ready_d = 1'b0;
            setup_d = 1'b0;
            count_d = '0;
            busy_d  = 1'b0;
          end else if (pkt_start_i && pkt_setup_i) begin
            // SETUP cannot be NAKed: drop the held packet and capture the new one.
            state_d     = ST_RECV;
            wr_ptr_d    = '0;
            setup_lat_d = 1'b1;
            ovf_d       = 1'b0;
            ready_d     = 1'b0;
            setup_d     = 1'b0;
            count_d     = '0;
            busy_d      = 1'b0;
          end else if (rd_req_i) begin
            if (rd_ptr_q < count_q) begin
              ram_re   = 1'b1;
              rd_ptr_d = rd_ptr_q + ONE_C;
            end else begin
              ram_clr = 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  usbf_sp_ram #(
    .DEPTH (DEPTH),
    .DW    (USB_EP0_DATA_DATA_W),
    .AW    (AW)
  ) u_ram (
    .clk_i   (phy_clk_i),
    .rstn_i  (rstn_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data_i),
    .re_i    (ram_re),
    .rclr_i  (ram_clr),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data_o)
  );

  assign rx_busy_o       = busy_q;
  assign rx_ready_o      = ready_q;
  assign rx_setup_o      = setup_q;
  assign rx_err_o        = err_q;
  assign rx_count_o      = count_q;
  assign rx_ready_intr_o = intr_q;

endmodule

// File: doc/usbf_ep_rx_buf.md
Name: usbf_ep_rx_buf

Overview:
- Per-endpoint RX packet buffer in the PHY clock domain.
- Captures one received OUT/SETUP data packet from the protocol engine.
- Holds the packet for the host and presents endpoint status to the hclk side.
- Answers synchronized host read-request pulses with one data byte each, stable until the next request, so the downstream bus synchronizer can sample it.

Parameters:
- DEPTH, 64, buffer capacity in bytes (power of two, max packet size).
- CNT_W, $clog2(DEPTH)+1, width of byte count.

Ports:
- phy_clk_i  in  1  PHY clock; only clock of the block.
- rstn_i  in  1  synchronous active-low reset.
- pkt_start_i  in  1  one-cycle pulse, start of data packet addressed to this EP.
- pkt_setup_i  in  1  sampled with pkt_start_i; 1 = SETUP packet.
- wr_valid_i  in  1  byte strobe during packet.
- wr_data_i  in  8  received byte.
- pkt_end_i  in  1  one-cycle pulse, end of packet.
- pkt_crc_err_i  in  1  sampled with pkt_end_i; 1 = CRC16/bit-stuff error.
- rd_req_i  in  1  synchronized host read pulse.
- rx_accept_i  in  1  synchronized host accept pulse (packet consumed).
- rx_flush_i  in  1  synchronized host flush pulse.
- rd_data_o  out  8  read byte, held between requests.
- rx_busy_o  out  1  buffer holds unread packet; protocol engine NAKs OUT.
- rx_ready_o  out  1  status level: valid packet available.
- rx_setup_o  out  1  status level: held packet is SETUP.
- rx_err_o  out  1  status level: last packet discarded (CRC error or overflow).
- rx_count_o  out  CNT_W  byte count of held packet.
- rx_ready_intr_o  out  1  one-cycle pulse on packet becoming ready.

Behaviour:
- Reset (rstn_i=0 at clock edge):
  - state=IDLE; all outputs 0; pointers 0.
  - Memory contents not reset.
- States: IDLE, RECV, READY.
- IDLE:
  - pkt_start_i → RECV; wr_ptr=0; latch pkt_setup_i; clear overflow flag.
  - wr_valid_i/pkt_end_i ignored.
- RECV:
  - wr_valid_i with wr_ptr<DEPTH → mem[wr_ptr]=wr_data_i, wr_ptr++.
  - wr_valid_i with wr_ptr==DEPTH → byte dropped, overflow flag set.
  - wr_valid_i and pkt_end_i in the same cycle: the byte is written and counted.
  - pkt_end_i with crc_err or overflow (including an overflow in the same cycle) → IDLE; rx_err_o=1; rx_ready_o stays 0; no interrupt.
  - pkt_end_i good → READY next cycle:
    - rx_ready_o=1, rx_err_o=0, rx_count_o=final wr_ptr, rx_setup_o=latched flag, rd_ptr=0.
    - rx_ready_intr_o=1 for exactly that cycle.
  - Zero-length good packet → READY with rx_count_o=0.
  - pkt_start_i while in RECV → restart: wr_ptr=0, re-latch setup, clear overflow.
- READY:
  - rx_busy_o=1.
  - rd_req_i with rd_ptr<rx_count_o → next cycle rd_data_o=mem[rd_ptr], rd_ptr++ (1-cycle latency).
  - rd_req_i with rd_ptr==rx_count_o → rd_data_o=0, rd_ptr unchanged.
  - rx_accept_i → IDLE; rx_ready_o, rx_setup_o, rx_count_o, rx_busy_o=0. rd_data_o holds its last value.
  - pkt_start_i with pkt_setup_i=0 → ignored (engine NAKs).
  - pkt_start_i with pkt_setup_i=1 → SETUP must always be accepted:
    - Held packet discarded; rx_ready_o=0 and rx_count_o=0.
    - rx_busy_o=0 from this point.
    - Enter RECV as above.
- Priority each cycle: reset > rx_flush_i > rx_accept_i > pkt_start_i > rd_req_i.
- rx_flush_i, any state:
  - → IDLE; rx_err_o, rx_ready_o, rx_setup_o, rx_count_o, rd_data_o, pointers cleared.
  - Any in-progress packet is dropped.
- rx_accept_i and rd_req_i in the same cycle → accept wins; rd_data_o unchanged.
- rx_ready_intr_o pulses are separated by at least one full packet reception (≥3 cycles), which satisfies pulse-synchronizer spacing.
- rx_busy_o = (state==READY), registered output.
- rx_count_o width: CNT_W bits so that DEPTH itself is representable.

Decomposition:
- Shared package/defines (usbf_cfg_defs):
  - USB_EP0_STS_RX_COUNT_W (= CNT_W).
  - USB_EP0_DATA_DATA_W (8).
  - Max packet size constant used for DEPTH.
  - State encoding localparams: IDLE=2'd0, RECV=2'd1, READY=2'd2.
- One natural sub-module: usbf_sp_ram (DEPTH x 8, single write port, registered read).
  - The buffer FSM instantiates it.
  - Its read register drives rd_data_o.

Test Plan:
- Good 4-byte OUT: pkt_start (setup=0), bytes 11,22,33,44, pkt_end (crc_err=0) → next cycle rx_ready_o=1, rx_count_o=4, one-cycle rx_ready_intr_o; four rd_req → rd_data_o=11,22,33,44, each 1 cycle after its request; fifth rd_req → rd_data_o=0.
- CRC error: 3 bytes then pkt_end with crc_err=1 → rx_err_o=1, rx_ready_o=0, no interrupt; next good 2-byte packet → rx_err_o=0, rx_count_o=2.
- Overflow, DEPTH=64: 65 bytes then pkt_end → rx_err_o=1, IDLE; exactly 64 bytes → rx_ready_o=1, rx_count_o=64.
- SETUP preemption: READY holding 8-byte OUT; OUT pkt_start → ignored, rx_busy_o stays 1; SETUP pkt_start + 8 bytes → rx_setup_o=1, rx_count_o=8, data equals new bytes.
- Flush vs accept: rx_flush_i and rx_accept_i in the same cycle while RECV with 5 bytes → IDLE, all status 0, later pkt_end ignored.
- Reset mid-RECV: rstn_i low one edge after 3 bytes → all outputs 0; a subsequent 1-byte packet reports rx_count_o=1.
